// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant, one burst (AR + all R beats)
// in flight on the shared master port. R fields are broadcast; valid is steered.
module axi_rd_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [15:0]             s_axi_arlen,
    input  logic [5:0]              s_axi_arsize,
    input  logic [3:0]              s_axi_arburst,
    input  logic [5:0]              s_axi_arprot,
    input  logic [1:0]              s_axi_arvalid,
    output logic [1:0]              s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic                    s_axi_rlast,
    output logic [1:0]              s_axi_rresp,
    output logic [1:0]              s_axi_rvalid,
    input  logic [1:0]              s_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic                    m_axi_rlast,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last, last_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        last_next     = last;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (s_axi_arvalid != 2'b00) begin
                    state_next = ADDR;
                    case (s_axi_arvalid)
                        2'b01:   grant_next = 1'b0;
                        2'b10:   grant_next = 1'b1;
                        default: grant_next = ~last;
                    endcase
                end
            end
            ADDR: begin
                m_axi_arvalid        = 1'b1;
                s_axi_arready[grant] = m_axi_arready;
                if (m_axi_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                m_axi_rready        = s_axi_rready[grant];
                s_axi_rvalid[grant] = m_axi_rvalid;
                // Burst ends on the accepted rlast beat; that requester loses the next tie.
                if (m_axi_rvalid && s_axi_rready[grant] && m_axi_rlast) begin
                    state_next = IDLE;
                    last_next  = grant;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_axi_araddr  = grant ? s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_araddr[ADDR_WIDTH-1:0];
    assign m_axi_arid    = grant ? s_axi_arid[2*ID_WIDTH-1:ID_WIDTH]       : s_axi_arid[ID_WIDTH-1:0];
    assign m_axi_arlen   = grant ? s_axi_arlen[15:8]   : s_axi_arlen[7:0];
    assign m_axi_arsize  = grant ? s_axi_arsize[5:3]   : s_axi_arsize[2:0];
    assign m_axi_arburst = grant ? s_axi_arburst[3:2]  : s_axi_arburst[1:0];
    assign m_axi_arprot  = grant ? s_axi_arprot[5:3]   : s_axi_arprot[2:0];

    assign s_axi_rdata = m_axi_rdata;
    assign s_axi_rid   = m_axi_rid;
    assign s_axi_rlast = m_axi_rlast;
    assign s_axi_rresp = m_axi_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both requesters and the
// downstream slave, with hand-chosen expected grants, fields and beats.
module tb_axi_rd_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] s_araddr;
    logic [2*IW-1:0] s_arid;
    logic [15:0]   s_arlen;
    logic [5:0]    s_arsize;
    logic [3:0]    s_arburst;
    logic [5:0]    s_arprot;
    logic [1:0]    s_arvalid;
    logic [1:0]    s_arready;
    logic [DW-1:0] s_rdata;
    logic [IW-1:0] s_rid;
    logic          s_rlast;
    logic [1:0]    s_rresp;
    logic [1:0]    s_rvalid;
    logic [1:0]    s_rready;
    logic [AW-1:0] m_araddr;
    logic [IW-1:0] m_arid;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [2:0]    m_arprot;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [IW-1:0] m_rid;
    logic          m_rlast;
    logic [1:0]    m_rresp;
    logic          m_rvalid;
    logic          m_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_araddr), .s_axi_arid(s_arid), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arprot(s_arprot),
        .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rid(s_rid), .s_axi_rlast(s_rlast),
        .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_araddr(m_araddr), .m_axi_arid(m_arid), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arprot(m_arprot),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rid(m_rid), .m_axi_rlast(m_rlast),
        .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id, input logic v);
        s_araddr[idx*AW +: AW] = addr;
        s_arid[idx*IW +: IW]   = id;
        s_arlen[idx*8 +: 8]    = len;
        s_arsize[idx*3 +: 3]   = 3'(idx + 2);
        s_arburst[idx*2 +: 2]  = 2'b01;
        s_arprot[idx*3 +: 3]   = 3'(idx + 1);
        s_arvalid[idx]         = v;
    endtask

    // Outside ADDR/DATA: no AR valid, no R path even with a stray beat and both rready high.
    task automatic idle_check(input string tag);
        m_rvalid = 1'b1;
        s_rready = 2'b11;
        #1;
        check($sformatf("%s.arvalid", tag), m_arvalid, 0);
        check($sformatf("%s.rready", tag), m_rready, 0);
        check($sformatf("%s.s_rvalid", tag), s_rvalid, 0);
        check($sformatf("%s.s_arready", tag), s_arready, 0);
        m_rvalid = 1'b0;
        s_rready = 2'b00;
    endtask

    task automatic expect_ar(input string tag, input int idx, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [IW-1:0] id, input int hold);
        for (int k = 0; k < hold; k++) begin
            m_arready = 1'b0;
            #1;
            check($sformatf("%s.hold%0d.arvalid", tag, k), m_arvalid, 1);
            check($sformatf("%s.hold%0d.araddr", tag, k), m_araddr, addr);
            check($sformatf("%s.hold%0d.arlen", tag, k), m_arlen, len);
            check($sformatf("%s.hold%0d.s_arready", tag, k), s_arready, 0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        check($sformatf("%s.arvalid", tag), m_arvalid, 1);
        check($sformatf("%s.araddr", tag), m_araddr, addr);
        check($sformatf("%s.arid", tag), m_arid, id);
        check($sformatf("%s.arlen", tag), m_arlen, len);
        check($sformatf("%s.arsize", tag), m_arsize, idx + 2);
        check($sformatf("%s.arburst", tag), m_arburst, 1);
        check($sformatf("%s.arprot", tag), m_arprot, idx + 1);
        check($sformatf("%s.s_arready", tag), s_arready, (idx == 1) ? 2 : 1);
        check($sformatf("%s.rready", tag), m_rready, 0);
        tick();
        m_arready = 1'b0;
    endtask

    // The non-granted requester keeps rready high so only steering by grant is exercised.
    task automatic beats(input string tag, input int idx, input int n,
                         input logic [IW-1:0] id, input bit toggle);
        int b   = 0;
        int cyc = 0;
        logic rdy;
        logic [DW-1:0] exp_data;
        while (b < n && cyc < 4 * n + 4) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            s_rready      = 2'b00;
            s_rready[1-idx] = 1'b1;
            s_rready[idx] = rdy;
            exp_data = 32'hD000_0000 + 32'(idx * 256 + b);
            m_rvalid = 1'b1;
            m_rdata  = exp_data;
            m_rid    = id;
            m_rlast  = (b == n - 1);
            m_rresp  = 2'(b);
            #1;
            check($sformatf("%s.c%0d.s_rvalid", tag, cyc), s_rvalid, (idx == 1) ? 2 : 1);
            check($sformatf("%s.c%0d.rready", tag, cyc), m_rready, rdy);
            check($sformatf("%s.c%0d.rdata", tag, cyc), s_rdata, exp_data);
            check($sformatf("%s.c%0d.rid", tag, cyc), s_rid, id);
            check($sformatf("%s.c%0d.rlast", tag, cyc), s_rlast, (b == n - 1));
            check($sformatf("%s.c%0d.rresp", tag, cyc), s_rresp, b % 4);
            check($sformatf("%s.c%0d.s_arready", tag, cyc), s_arready, 0);
            if (rdy) b++;
            cyc++;
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 2'b00;
        check($sformatf("%s.beats", tag), b, n);
    endtask

    initial begin
        rst = 1'b1;
        s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
        m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0;
        m_rresp = '0; m_rvalid = 1'b0;
        repeat (3) tick();
        #1;
        check("reset.arvalid", m_arvalid, 0);
        check("reset.rready", m_rready, 0);
        check("reset.s_arready", s_arready, 0);
        check("reset.s_rvalid", s_rvalid, 0);
        rst = 1'b0;

        // Single requester 0, 4-beat burst.
        set_req(0, 32'h1000, 8'd3, 4'h5, 1'b1);
        idle_check("t1.req");
        tick();
        expect_ar("t1", 0, 32'h1000, 8'd3, 4'h5, 0);
        set_req(0, 32'h1000, 8'd3, 4'h5, 1'b0);
        beats("t1", 0, 4, 4'h5, 1'b0);
        idle_check("t1.end");

        // Both request continuously after reset: grants 0,1,0,1 with one IDLE gap each.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 32'h1000, 8'd1, 4'h3, 1'b1);
        set_req(1, 32'h2000, 8'd0, 4'hA, 1'b1);
        idle_check("t2.req");
        tick();
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) begin
                expect_ar($sformatf("t2.g%0d", g), 0, 32'h1000, 8'd1, 4'h3, 0);
                beats($sformatf("t2.g%0d", g), 0, 2, 4'h3, 1'b0);
            end else begin
                expect_ar($sformatf("t2.g%0d", g), 1, 32'h2000, 8'd0, 4'hA, 0);
                beats($sformatf("t2.g%0d", g), 1, 1, 4'hA, 1'b0);
            end
            if (g == 3) begin
                s_arvalid = 2'b00;
            end
            idle_check($sformatf("t2.gap%0d", g));
            if (g < 3) tick();
        end

        // Requester 1 alone, rready toggling 1,0,1,0.
        set_req(1, 32'h3000, 8'd3, 4'hA, 1'b1);
        idle_check("t3.req");
        tick();
        expect_ar("t3", 1, 32'h3000, 8'd3, 4'hA, 0);
        set_req(1, 32'h3000, 8'd3, 4'hA, 1'b0);
        beats("t3", 1, 4, 4'hA, 1'b1);
        idle_check("t3.end");

        // arlen=0 with arready held low for 5 cycles.
        set_req(0, 32'h4000, 8'd0, 4'h7, 1'b1);
        idle_check("t4.req");
        tick();
        expect_ar("t4", 0, 32'h4000, 8'd0, 4'h7, 5);
        set_req(0, 32'h4000, 8'd0, 4'h7, 1'b0);
        beats("t4", 0, 1, 4'h7, 1'b0);
        idle_check("t4.end");

        // Reset after beat 2 of 4; last burst was requester 0, so only reset makes s0 win next.
        set_req(0, 32'h5000, 8'd3, 4'h2, 1'b1);
        idle_check("t5.req");
        tick();
        expect_ar("t5", 0, 32'h5000, 8'd3, 4'h2, 0);
        set_req(0, 32'h5000, 8'd3, 4'h2, 1'b0);
        for (int b = 0; b < 2; b++) begin
            s_rready = 2'b01;
            m_rvalid = 1'b1;
            m_rdata  = 32'(b);
            m_rlast  = 1'b0;
            #1;
            check($sformatf("t5.b%0d.s_rvalid", b), s_rvalid, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 32'h5000, 8'd3, 4'h2, 1'b1);
        set_req(1, 32'h6000, 8'd0, 4'h9, 1'b1);
        idle_check("t5.after_rst");
        tick();
        expect_ar("t5.regrant", 0, 32'h5000, 8'd3, 4'h2, 0);
        s_arvalid = 2'b00;
        beats("t5.regrant", 0, 4, 4'h2, 1'b0);
        idle_check("t5.end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter
Overview: Two-requester AXI4 read-channel arbiter that shares one AXI4 read master port, e.g. one port toward axi_cdc or memory shared by instruction and data fetch. Round-robin grant, one burst in flight: the AR handshake plus all R beats up to rlast. Single clock domain; ID passes through untouched. Requester fields are packed: index 0 occupies the low slice.
Parameters:
DATA_WIDTH, 32, R data width in bits
ADDR_WIDTH, 32, AR address width in bits
ID_WIDTH, 4, AR/R ID width in bits
Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_araddr  in  2*ADDR_WIDTH  per-requester read address
s_axi_arid  in  2*ID_WIDTH  per-requester ID
s_axi_arlen  in  2*8  per-requester burst length
s_axi_arsize  in  2*3  per-requester beat size
s_axi_arburst  in  2*2  per-requester burst type
s_axi_arprot  in  2*3  per-requester protection
s_axi_arvalid  in  2  per-requester AR valid
s_axi_arready  out  2  per-requester AR ready
s_axi_rdata  out  DATA_WIDTH  read data, broadcast to both requesters
s_axi_rid  out  ID_WIDTH  read ID, broadcast
s_axi_rlast  out  1  last beat, broadcast
s_axi_rresp  out  2  response, broadcast
s_axi_rvalid  out  2  per-requester R valid; only the granted bit can be 1
s_axi_rready  in  2  per-requester R ready
m_axi_araddr/arid/arlen/arsize/arburst/arprot  out  ADDR_WIDTH/ID_WIDTH/8/3/2/3  granted requester's AR fields
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata/rid/rlast/rresp  in  DATA_WIDTH/ID_WIDTH/1/2  R fields
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- State machine and arbitration:
  - Registers: state in {IDLE, ADDR, DATA}, grant (1 bit), last (1 bit).
  - Reset: state=IDLE, last=1 so requester 0 wins the first tie.
  - Reset values: s_axi_arready=0, s_axi_rvalid=0, m_axi_arvalid=0, m_axi_rready=0.
  - IDLE, neither arvalid set: stay IDLE.
  - IDLE, exactly one arvalid set: grant<=that index; go to ADDR.
  - IDLE, both arvalid set: grant<=~last; go to ADDR.
  - ADDR: m_axi_arvalid=1; m_axi_ar* = combinational mux of s_axi_ar*[grant].
  - ADDR: s_axi_arready[grant]=m_axi_arready; the other arready bit=0.
  - ADDR to DATA on m_axi_arvalid&&m_axi_arready.
  - DATA: m_axi_rready=s_axi_rready[grant]; s_axi_rvalid[grant]=m_axi_rvalid; the other rvalid bit=0.
  - DATA: rdata/rid/rlast/rresp forwarded combinationally, zero latency.
  - DATA on a beat with m_axi_rvalid&&m_axi_rready&&m_axi_rlast: go to IDLE, last<=grant.
- Latency and throughput:
  - Latency: request sampled in IDLE at cycle N; m_axi_arvalid=1 at N+1.
  - Minimum gap between the final rlast beat and the next m_axi_arvalid: 1 IDLE cycle.
  - Strict alternation when both requesters request continuously.
- Outside DATA: m_axi_rready=0; a stray m_axi_rvalid is not forwarded.
- Outside ADDR: both s_axi_arready bits are 0.
- arlen=0: a single beat carrying rlast returns the block to IDLE.
- Requester dropping arvalid after grant violates AXI and is unsupported; the AR fields must be held stable until handshake.
- rst asserted mid-burst: next cycle is IDLE and outstanding beats are discarded; the downstream must be reset together with this block.
Test Plan:
- Only s0 requests araddr=0x1000, arlen=3 -> m_axi_araddr=0x1000 with m_axi_arvalid one cycle later; 4 beats delivered to s0 only; s_axi_rvalid[1]=0 throughout.
- Both request from IDLE right after reset -> s0 granted first, then s1; a second simultaneous pair grants s0 again; grants alternate 0,1,0,1.
- s1 holds arvalid during s0's burst -> s1 gets no arready until s0's rlast beat; s1's m_axi_arvalid appears exactly 2 cycles after that beat.
- Granted requester's rready toggles 1,0,1,0 over a 4-beat burst -> m_axi_rready mirrors it; no beat is lost or duplicated; rid passes through unchanged (e.g. 0xA).
- arlen=0, and m_axi_arready held low for 5 cycles -> m_axi_arvalid and the AR fields stay stable for those 5 cycles; one beat completes the burst and the block returns to IDLE.
- rst pulsed for one cycle mid-burst (after beat 2 of 4) -> all valid/ready outputs are 0 the next cycle; with both requesting after reset, s0 is granted first.
